uart_rx_frame_check: RTL and testbench
======================================

// Module: uart_rx_frame_check
// PURPOSE
//  Serial-rate UART RX frame checker: parity, stop-bit and counter stage after the bit sampler.
//  Takes one sampled bit per bit_valid strobe after start detection and shifts in data LSB first.
//  Accumulates parity on the fly; supports even, odd, mark and space parity, or no parity.
//  Checks one or two stop bits and reports per-frame status plus saturating error counters.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame (5..9)
//  CNT_WIDTH   8  width of each saturating error counter
// PORTS
//  clk           in   1           system clock
//  rst           in   1           synchronous, active-high reset
//  frame_start   in   1           1-cycle pulse: start bit validated by the sampler
//  bit_valid     in   1           1-cycle strobe: sampled_bit holds the next frame bit
//  sampled_bit   in   1           majority-sampled line value
//  par_en        in   1           1 = frame carries a parity bit
//  par_mode      in   2           00 even, 01 odd, 10 mark (1), 11 space (0)
//  stop_two      in   1           1 = two stop bits expected
//  err_clr       in   1           1-cycle pulse: clear both error counters
//  p_out         out  DATA_WIDTH  received data word, LSB = first data bit
//  frame_done    out  1           1-cycle pulse: frame complete, status valid
//  data_valid    out  1           frame_done AND no par_err AND no stop_err
//  par_err       out  1           parity mismatch on the last frame
//  stop_err      out  1           a stop bit sampled 0 on the last frame
//  busy          out  1           FSM not in IDLE
//  par_err_cnt   out  CNT_WIDTH   saturating count of parity errors
//  stop_err_cnt  out  CNT_WIDTH   saturating count of stop errors
// BEHAVIOUR
//  Reset: every output 0, FSM in IDLE, bit counter and running parity 0.
//  FSM: IDLE -> DATA -> PARITY (only if par_en) -> STOP1 -> STOP2 (only if stop_two) -> IDLE.
//  IDLE:
//   - frame_start -> DATA.
//   - par_en, par_mode and stop_two are latched here; later changes do not affect the frame.
//   - Bit counter and running parity clear to 0.
//   - par_err and stop_err clear to 0.
//   - bit_valid is ignored in IDLE, including when it coincides with frame_start.
//  DATA: each bit_valid shifts sampled_bit in at MSB and shifts right, XORs it into running parity.
//   After the DATA_WIDTH-th bit: -> PARITY if par_en, else -> STOP1.
//  PARITY: expected bit = running parity (even), ~parity (odd), 1 (mark), 0 (space).
//   On bit_valid: par_err <= sampled_bit != expected, then -> STOP1.
//  STOP1/STOP2: on bit_valid, a sampled 0 sets stop_err (sticky within the frame).
//   STOP1 -> STOP2 if stop_two, else finish; STOP2 -> finish.
//  Finish:
//   - frame_done, and data_valid when error-free, pulse high exactly 1 cycle after the final stop bit_valid.
//   - The FSM is in IDLE in that same cycle.
//  Output holding:
//   - p_out, par_err and stop_err update only at finish.
//   - They hold until the next finish or reset.
//   - The mid-frame clear applies to the internal copies only.
//  Counters: on finish, each counter increments by 1 if its error is set, saturating at all-ones.
//   err_clr with no same-cycle increment -> 0.
//   err_clr in the same cycle as an increment -> 1 (the error is not lost).
//  frame_start outside IDLE (resync):
//   - Abort the frame with no frame_done and no counter update.
//   - Restart DATA with cleared bit counter and parity.
//  bit_valid and frame_start never assert together outside IDLE; if they do, frame_start wins.
//  rst mid-frame: back to IDLE at once; nothing is reported for the partial frame.
//  busy = (state != IDLE); it is combinational from the state register.
// TESTING
//  1. Even, 1 stop: start, bits of 0xA5, parity 0, stop 1.
//     -> p_out=0xA5, frame_done=1, data_valid=1, par_err=0.
//  2. Odd: 0xA5 with parity 0 -> par_err=1, data_valid=0, par_err_cnt=1; repeat with parity 1 -> par_err=0, count stays 1.
//  3. Mark/space, no-parity: mark, 0x00, parity bit 0 -> par_err=1.
//     par_en=0 -> frame_done 1 cycle after the 9th bit_valid.
//  4. Two stop bits: stop_two=1, STOP2 sampled 0 -> stop_err=1, stop_err_cnt=1.
//     stop_two flipped mid-frame -> latched value is used.
//  5. Saturation: CNT_WIDTH=2, 5 parity-error frames -> par_err_cnt=3.
//     err_clr coinciding with an error finish -> par_err_cnt=1.
//  6. Abort/reset:
//     - frame_start after 3 data bits -> no frame_done; the next full frame decodes correctly.
//     - rst mid-frame -> all outputs 0, busy=0.

Source files
------------

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: takes sampled bits after start detection, rebuilds the data
// word LSB first, checks parity and stop bits, and keeps saturating error counters.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for frame_start; frame configuration tracks inputs
// DATA   | shifting in DATA_WIDTH data bits, accumulating parity
// PARITY | comparing the parity bit against the expected value
// STOP1  | checking the first stop bit
// STOP2  | checking the second stop bit (two-stop frames only)
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  frame_start_i,
    input  logic                  bit_valid_i,
    input  logic                  sampled_bit_i,
    input  logic                  par_en_i,
    input  logic [1:0]            par_mode_i,
    input  logic                  stop_two_i,
    input  logic                  err_clr_i,
    output logic [DATA_WIDTH-1:0] p_out_o,
    output logic                  frame_done_o,
    output logic                  data_valid_o,
    output logic                  par_err_o,
    output logic                  stop_err_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  par_err_cnt_o,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt_o
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP1  = 3'd3,
        STOP2  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  par_acc_q, par_acc_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_err_int_q, par_err_int_d;
    logic                  stop_err_int_q, stop_err_int_d;
    logic                  par_en_q, par_en_d;
    logic [1:0]            par_mode_q, par_mode_d;
    logic                  stop_two_q, stop_two_d;
    logic [DATA_WIDTH-1:0] p_out_q, p_out_d;
    logic                  par_err_q, par_err_d;
    logic                  stop_err_q, stop_err_d;
    logic                  frame_done_q, frame_done_d;
    logic                  data_valid_q, data_valid_d;
    logic [CNT_WIDTH-1:0]  par_cnt_q, par_cnt_d;
    logic [CNT_WIDTH-1:0]  stop_cnt_q, stop_cnt_d;
    logic                  finish;
    logic                  par_exp;

    // Expected parity bit for the latched parity mode
    always_comb begin
        par_exp = 1'b0;
        case (par_mode_q)
            2'b00:   par_exp = par_acc_q;
            2'b01:   par_exp = ~par_acc_q;
            2'b10:   par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    // Next-state logic: frame sequencing, shifting, parity and stop checks
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        par_acc_d      = par_acc_q;
        shift_d        = shift_q;
        par_err_int_d  = par_err_int_q;
        stop_err_int_d = stop_err_int_q;
        par_en_d       = par_en_q;
        par_mode_d     = par_mode_q;
        stop_two_d     = stop_two_q;
        finish         = 1'b0;

        if (state_q == IDLE) begin
            bit_cnt_d      = '0;
            par_acc_d      = 1'b0;
            par_err_int_d  = 1'b0;
            stop_err_int_d = 1'b0;
            par_en_d       = par_en_i;
            par_mode_d     = par_mode_i;
            stop_two_d     = stop_two_i;
            if (frame_start_i) begin
                state_d = DATA;
            end
        end else if (frame_start_i) begin
            // Resync: drop the partial frame silently and restart data capture
            state_d        = DATA;
            bit_cnt_d      = '0;
            par_acc_d      = 1'b0;
            par_err_int_d  = 1'b0;
            stop_err_int_d = 1'b0;
        end else if (bit_valid_i) begin
            case (state_q)
                DATA: begin
                    shift_d   = {sampled_bit_i, shift_q[DATA_WIDTH-1:1]};
                    par_acc_d = par_acc_q ^ sampled_bit_i;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    par_err_int_d = (sampled_bit_i != par_exp);
                    state_d       = STOP1;
                end
                STOP1: begin
                    if (!sampled_bit_i) begin
                        stop_err_int_d = 1'b1;
                    end
                    if (stop_two_q) begin
                        state_d = STOP2;
                    end else begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end
                end
                STOP2: begin
                    if (!sampled_bit_i) begin
                        stop_err_int_d = 1'b1;
                    end
                    state_d = IDLE;
                    finish  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Reported status and saturating counters; the clear wins over a stale count
    // but never swallows an increment arriving in the same cycle
    always_comb begin
        p_out_d      = p_out_q;
        par_err_d    = par_err_q;
        stop_err_d   = stop_err_q;
        frame_done_d = finish;
        data_valid_d = finish & ~par_err_int_d & ~stop_err_int_d;
        par_cnt_d    = par_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        if (finish) begin
            p_out_d    = shift_q;
            par_err_d  = par_err_int_d;
            stop_err_d = stop_err_int_d;
        end
        if (err_clr_i) begin
            par_cnt_d  = (finish && par_err_int_d)  ? CNT_WIDTH'(1) : '0;
            stop_cnt_d = (finish && stop_err_int_d) ? CNT_WIDTH'(1) : '0;
        end else begin
            if (finish && par_err_int_d && par_cnt_q != CNT_MAX) begin
                par_cnt_d = par_cnt_q + CNT_WIDTH'(1);
            end
            if (finish && stop_err_int_d && stop_cnt_q != CNT_MAX) begin
                stop_cnt_d = stop_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            par_acc_q      <= 1'b0;
            shift_q        <= '0;
            par_err_int_q  <= 1'b0;
            stop_err_int_q <= 1'b0;
            par_en_q       <= 1'b0;
            par_mode_q     <= 2'b00;
            stop_two_q     <= 1'b0;
            p_out_q        <= '0;
            par_err_q      <= 1'b0;
            stop_err_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            data_valid_q   <= 1'b0;
            par_cnt_q      <= '0;
            stop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            par_acc_q      <= par_acc_d;
            shift_q        <= shift_d;
            par_err_int_q  <= par_err_int_d;
            stop_err_int_q <= stop_err_int_d;
            par_en_q       <= par_en_d;
            par_mode_q     <= par_mode_d;
            stop_two_q     <= stop_two_d;
            p_out_q        <= p_out_d;
            par_err_q      <= par_err_d;
            stop_err_q     <= stop_err_d;
            frame_done_q   <= frame_done_d;
            data_valid_q   <= data_valid_d;
            par_cnt_q      <= par_cnt_d;
            stop_cnt_q     <= stop_cnt_d;
        end
    end

    assign p_out_o        = p_out_q;
    assign frame_done_o   = frame_done_q;
    assign data_valid_o   = data_valid_q;
    assign par_err_o      = par_err_q;
    assign stop_err_o     = stop_err_q;
    assign busy_o         = (state_q != IDLE);
    assign par_err_cnt_o  = par_cnt_q;
    assign stop_err_cnt_o = stop_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check (DATA_WIDTH 8, CNT_WIDTH 2).
module tb_uart_rx_frame_check;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       frame_start_i = 1'b0;
    logic       bit_valid_i = 1'b0;
    logic       sampled_bit_i = 1'b0;
    logic       par_en_i = 1'b0;
    logic [1:0] par_mode_i = 2'b00;
    logic       stop_two_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic [7:0] p_out_o;
    logic       frame_done_o;
    logic       data_valid_o;
    logic       par_err_o;
    logic       stop_err_o;
    logic       busy_o;
    logic [1:0] par_err_cnt_o;
    logic [1:0] stop_err_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic clr_on_last = 1'b0;

    uart_rx_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .frame_start_i  (frame_start_i),
        .bit_valid_i    (bit_valid_i),
        .sampled_bit_i  (sampled_bit_i),
        .par_en_i       (par_en_i),
        .par_mode_i     (par_mode_i),
        .stop_two_i     (stop_two_i),
        .err_clr_i      (err_clr_i),
        .p_out_o        (p_out_o),
        .frame_done_o   (frame_done_o),
        .data_valid_o   (data_valid_o),
        .par_err_o      (par_err_o),
        .stop_err_o     (stop_err_o),
        .busy_o         (busy_o),
        .par_err_cnt_o  (par_err_cnt_o),
        .stop_err_cnt_o (stop_err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (frame_done_o) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic start_frame(input logic with_bv);
        frame_start_i = 1'b1;
        bit_valid_i   = with_bv;
        sampled_bit_i = 1'b1;
        step(1);
        frame_start_i = 1'b0;
        bit_valid_i   = 1'b0;
        step(1);
    endtask

    task automatic send_bit(input logic b, input logic clr);
        bit_valid_i   = 1'b1;
        sampled_bit_i = b;
        err_clr_i     = clr;
        step(1);
        bit_valid_i   = 1'b0;
        err_clr_i     = 1'b0;
    endtask

    // Full frame; returns #1 after the edge that took the final stop bit
    task automatic send_frame(input logic [7:0] data, input logic use_par, input logic pbit,
                              input logic two, input logic s1, input logic s2);
        start_frame(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(data[i], 1'b0);
            step(1);
        end
        if (use_par) begin
            send_bit(pbit, 1'b0);
            step(1);
        end
        if (two) begin
            send_bit(s1, 1'b0);
            step(1);
            send_bit(s2, clr_on_last);
        end else begin
            send_bit(s1, clr_on_last);
        end
    endtask

    task automatic pulse_clr();
        err_clr_i = 1'b1;
        step(1);
        err_clr_i = 1'b0;
    endtask

    initial begin
        step(3);
        rst_i = 1'b0;
        step(1);
        chk("rst_pout", p_out_o, 0);
        chk("rst_done", frame_done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_pcnt", par_err_cnt_o, 0);

        // 1: even parity, one stop; bit_valid alongside frame_start must be ignored
        par_en_i = 1'b1; par_mode_i = 2'b00; stop_two_i = 1'b0;
        start_frame(1'b1);
        chk("t1_busy", busy_o, 1);
        for (int i = 0; i < 8; i++) begin
            send_bit((8'hA5 >> i) & 1'b1, 1'b0);
            step(1);
        end
        send_bit(1'b0, 1'b0);
        step(1);
        send_bit(1'b1, 1'b0);
        chk("t1_pout", p_out_o, 32'hA5);
        chk("t1_done", frame_done_o, 1);
        chk("t1_dv", data_valid_o, 1);
        chk("t1_perr", par_err_o, 0);
        chk("t1_serr", stop_err_o, 0);
        chk("t1_idle", busy_o, 0);
        step(1);
        chk("t1_done_pulse", frame_done_o, 0);
        chk("t1_pout_hold", p_out_o, 32'hA5);

        // 2: odd parity, wrong then right
        par_mode_i = 2'b01;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t2_perr", par_err_o, 1);
        chk("t2_dv", data_valid_o, 0);
        chk("t2_pcnt", par_err_cnt_o, 1);
        step(1);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t2b_perr", par_err_o, 0);
        chk("t2b_dv", data_valid_o, 1);
        chk("t2b_pcnt", par_err_cnt_o, 1);
        step(1);

        // 3: mark with a 0 parity bit, space with 0, then no parity
        par_mode_i = 2'b10;
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t3_mark_perr", par_err_o, 1);
        chk("t3_mark_pcnt", par_err_cnt_o, 2);
        step(1);
        par_mode_i = 2'b11;
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t3_space_perr", par_err_o, 0);
        step(1);
        par_en_i = 1'b0;
        start_frame(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit((8'h3C >> i) & 1'b1, 1'b0);
            step(1);
        end
        chk("t3_nopar_busy8", busy_o, 1);
        chk("t3_nopar_nodone8", frame_done_o, 0);
        send_bit(1'b1, 1'b0);
        chk("t3_nopar_done9", frame_done_o, 1);
        chk("t3_nopar_pout", p_out_o, 32'h3C);
        chk("t3_nopar_dv", data_valid_o, 1);
        chk("t3_pcnt_kept", par_err_cnt_o, 2);
        step(1);

        // 4: two stop bits, bad second stop; then stop_two flipped mid-frame
        stop_two_i = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_serr", stop_err_o, 1);
        chk("t4_scnt", stop_err_cnt_o, 1);
        chk("t4_dv", data_valid_o, 0);
        chk("t4_pout", p_out_o, 32'h5A);
        step(1);
        start_frame(1'b0);
        stop_two_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_bit((8'hC3 >> i) & 1'b1, 1'b0);
            step(1);
        end
        send_bit(1'b1, 1'b0);
        chk("t4b_nodone_stop1", frame_done_o, 0);
        chk("t4b_busy_stop1", busy_o, 1);
        step(1);
        send_bit(1'b1, 1'b0);
        chk("t4b_done_stop2", frame_done_o, 1);
        chk("t4b_serr", stop_err_o, 0);
        chk("t4b_pout", p_out_o, 32'hC3);
        chk("t4b_scnt", stop_err_cnt_o, 1);
        step(1);

        // 5: clear, saturate at 3, clear coinciding with an error finish
        pulse_clr();
        chk("t5_clr_pcnt", par_err_cnt_o, 0);
        chk("t5_clr_scnt", stop_err_cnt_o, 0);
        par_en_i = 1'b1; par_mode_i = 2'b00;
        for (int k = 0; k < 5; k++) begin
            send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            step(1);
        end
        chk("t5_sat", par_err_cnt_o, 3);
        clr_on_last = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        clr_on_last = 1'b0;
        chk("t5_clr_inc", par_err_cnt_o, 1);
        chk("t5_clr_inc_s", stop_err_cnt_o, 0);
        step(1);

        // 6: resync after 3 data bits, then a clean frame
        done_cnt = 0;
        start_frame(1'b0);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, 1'b0);
            step(1);
        end
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6_pout", p_out_o, 32'h96);
        chk("t6_dv", data_valid_o, 1);
        chk("t6_perr", par_err_o, 0);
        step(1);
        chk("t6_one_done", done_cnt, 1);
        chk("t6_pcnt", par_err_cnt_o, 1);

        // reset mid-frame
        start_frame(1'b0);
        send_bit(1'b1, 1'b0);
        step(1);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_pout", p_out_o, 0);
        chk("t6_rst_pcnt", par_err_cnt_o, 0);
        chk("t6_rst_scnt", stop_err_cnt_o, 0);
        chk("t6_rst_flags", {frame_done_o, data_valid_o, par_err_o, stop_err_o}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
